zacore_mem_responder: RTL and testbench
=======================================

// Module: zacore_mem_responder
// PURPOSE
// - Memory-side responder for the zacore_top memory interface.
// - Services the core's instruction-fetch, data-read and data-write requests from one internal word array.
// - Returns read data on one shared bus after a fixed latency.
// - Arbitrates fetch against data traffic; used as the simulation/FPGA memory behind the core.
// PARAMETERS
// - DEPTH_WORDS   4096  number of 32-bit words; power of 2, >= 2
// - LATENCY       1     cycles from grant to o_rvalid; legal 1..4
// - STARVE_LIMIT  4     consecutive fetch denials before fetch is forced to win; 1..15
// PORTS
// - i_clk              in   1   clock; all logic on rising edge
// - i_rst              in   1   reset; asynchronous assert, active-low; deassert sync to i_clk
// - i_fetch_req        in   1   instruction fetch request
// - i_read_req         in   1   data read request
// - i_write_req        in   1   data write request
// - i_fetch_addr       in   32  fetch byte address
// - i_data_addr        in   32  data byte address
// - i_data_write       in   32  write data
// - i_data_write_mask  in   4   byte enables; bit n selects bits [8n+7:8n]
// - o_fetch_gnt        out  1   fetch accepted this cycle
// - o_data_gnt         out  1   data request (read or write) accepted this cycle
// - o_data_read        out  32  read/fetch response data
// - o_rvalid           out  1   o_data_read valid this cycle
// - o_rsrc             out  1   response source: 0 = fetch, 1 = data
// - o_err              out  1   pulses with a response or write grant if access was bad
// BEHAVIOUR
// - Reset (i_rst=0):
//   - all outputs 0; response pipeline emptied; starve counter 0.
//   - Memory array is NOT cleared.
//   - Reset mid-operation discards in-flight responses; none are emitted afterwards.
// - Accepts at most one access per cycle.
// - Grants are combinational from this cycle's requests. A request not granted must be held by the core.
// - Arbitration:
//   - Data (read or write) beats fetch, unless starve_cnt == STARVE_LIMIT; then fetch wins.
//   - starve_cnt increments when fetch is requested and denied.
//   - It clears on any fetch grant or when fetch is not requested, and saturates at STARVE_LIMIT.
// - i_read_req & i_write_req together is a protocol error:
//   - Treated as a write; the read is dropped.
//   - o_err pulses in the grant cycle.
// - Address mapping:
//   - word index = addr[$clog2(DEPTH_WORDS)+1:2]; addr[1:0] ignored (aligned accesses only).
//   - Out of range when addr >= DEPTH_WORDS*4.
// - Write:
//   - Committed at the grant edge; only masked bytes change; mask 4'b0000 is a legal no-op.
//   - No response is produced.
//   - Out-of-range write: dropped, o_err=1 in the grant cycle.
// - Read/fetch:
//   - Array read in the grant cycle, then a LATENCY-deep shift pipeline of {valid, src, data, err}.
//   - o_rvalid asserts exactly LATENCY cycles after the grant edge, for 1 cycle.
//   - Out-of-range: data 32'h0, o_err=1 alongside o_rvalid.
// - Ordering: responses return in grant order; back-to-back grants give back-to-back o_rvalid.
// - Hazards: a read granted the cycle after a write to the same word returns the new data. Array reads see all earlier committed writes.
// - Every bit of o_data_read is 0 when o_rvalid=0.
// STRUCTURE
// - zacore_pkg holds:
//   - typedef logic [31:0] word_t
//   - typedef logic [3:0] mask_t
//   - typedef enum logic {SRC_FETCH=1'b0, SRC_DATA=1'b1} src_t
//   - typedef struct packed {logic valid; src_t src; word_t data; logic err;} rsp_t
// - Sub-module zacore_mem_array:
//   - DEPTH_WORDS x 32 storage; byte-masked synchronous write; combinational read.
//   - No reset.
// - Top level holds: arbiter with starve counter, address range check, rsp_t pipeline.
// TESTING
// - Write 32'hDEADBEEF to 0x10 (mask 4'hF), then read 0x10 -> o_rvalid after LATENCY, data 32'hDEADBEEF, o_rsrc=1.
// - Write 32'h000000AA to 0x10 with mask 4'b0001 -> read back 32'hDEADBEAA.
// - fetch+read held every cycle, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, pattern repeats; responses in grant order.
// - Read 0x4000 with DEPTH_WORDS=4096 -> data 0, o_err=1. Write there -> o_err=1, array unchanged.
// - Read and write requested in the same cycle to 0x20 -> write commits, o_err=1, no response.
// - Grant a read, assert i_rst before o_rvalid -> no o_rvalid ever; memory still holds prior writes after reset.

Source files
------------

// File: rtl/zacore_pkg.sv
// -----------------------------------------------------------------------------
// zacore_pkg
// Shared types for the zacore memory responder: data word, byte mask,
// response source tag and the response record carried down the read pipeline.
// -----------------------------------------------------------------------------
package zacore_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  mask_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_t;

  typedef struct packed {
    logic  valid;
    src_t  src;
    word_t data;
    logic  err;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{valid: 1'b0, src: SRC_FETCH, data: '0, err: 1'b0};

endpackage

// File: rtl/zacore_mem_array.sv
// -----------------------------------------------------------------------------
// zacore_mem_array
// DEPTH_WORDS x 32-bit storage with a byte-masked synchronous write port and a
// combinational read port.
//
// Ports
//   clk    in   clock; write commits on the rising edge
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
//   wmask  in   byte enables; bit n selects wdata[8n+7:8n]
//   raddr  in   read word index
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module zacore_mem_array
  import zacore_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  mask_t         wmask,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  // NOTE: the storage array deliberately has no reset; its contents must
  // survive a core reset, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zacore_mem_responder.sv
// -----------------------------------------------------------------------------
// zacore_mem_responder
// Memory-side responder for the zacore memory interface. Arbitrates the
// instruction-fetch port against the data port (data wins unless fetch has
// been starved STARVE_LIMIT times), services one access per cycle from a
// single word array, and returns read/fetch data on a shared bus LATENCY
// cycles after the grant.
//
// Ports
//   i_clk              in   clock, rising edge
//   i_rst              in   asynchronous active-low reset
//   i_fetch_req        in   instruction fetch request
//   i_read_req         in   data read request
//   i_write_req        in   data write request
//   i_fetch_addr       in   fetch byte address
//   i_data_addr        in   data byte address
//   i_data_write       in   write data
//   i_data_write_mask  in   write byte enables
//   o_fetch_gnt        out  fetch accepted this cycle
//   o_data_gnt         out  data read/write accepted this cycle
//   o_data_read        out  response data (0 when o_rvalid=0)
//   o_rvalid           out  response valid
//   o_rsrc             out  response source: 0 fetch, 1 data
//   o_err              out  bad access, with a response or a write grant
// -----------------------------------------------------------------------------
module zacore_mem_responder
  import zacore_pkg::*;
#(
  parameter int DEPTH_WORDS  = 4096,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_fetch_req,
  input  logic  i_read_req,
  input  logic  i_write_req,
  input  word_t i_fetch_addr,
  input  word_t i_data_addr,
  input  word_t i_data_write,
  input  mask_t i_data_write_mask,
  output logic  o_fetch_gnt,
  output logic  o_data_gnt,
  output word_t o_data_read,
  output logic  o_rvalid,
  output logic  o_rsrc,
  output logic  o_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  // Byte-address limit kept 34 bits wide so the largest legal depth cannot wrap.
  localparam logic [33:0] BYTE_LIMIT = 34'(DEPTH_WORDS) << 2;

  logic [3:0] starve_cnt;
  logic       starved;
  logic       data_req;
  logic       fetch_win;
  logic       data_win;
  logic       write_gnt;
  logic       read_gnt;
  word_t      acc_addr;
  logic       acc_oor;
  word_t      arr_rdata;
  rsp_t       rsp_in;
  rsp_t       rsp_out;
  rsp_t       pipe [LATENCY];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign data_req = i_read_req | i_write_req;
  assign starved  = (starve_cnt == 4'(STARVE_LIMIT));

  // NOTE: grants are combinational, so they are qualified with i_rst to keep
  // every output at 0 for the whole time reset is asserted.
  assign fetch_win = i_rst & i_fetch_req & (~data_req | starved);
  assign data_win  = i_rst & data_req & ~fetch_win;

  // Read+write together is treated as a write; the read is dropped.
  assign write_gnt = data_win & i_write_req;
  assign read_gnt  = data_win & ~i_write_req;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      starve_cnt <= '0;
    end else if (i_fetch_req && !fetch_win) begin
      if (!starved) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Address selection and range check (one access per cycle, so one check)
  // ---------------------------------------------------------------------------
  assign acc_addr = fetch_win ? i_fetch_addr : i_data_addr;
  assign acc_oor  = {2'b00, acc_addr} >= BYTE_LIMIT;

  zacore_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (i_clk),
    .we    (write_gnt & ~acc_oor),
    .waddr (acc_addr[AW+1:2]),
    .wdata (i_data_write),
    .wmask (i_data_write_mask),
    .raddr (acc_addr[AW+1:2]),
    .rdata (arr_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response pipeline: the array is read in the grant cycle and the result
  // travels LATENCY stages before reaching the outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_in       = RSP_IDLE;
    rsp_in.valid = fetch_win | read_gnt;
    rsp_in.src   = fetch_win ? SRC_FETCH : SRC_DATA;
    rsp_in.data  = (rsp_in.valid && !acc_oor) ? arr_rdata : '0;
    rsp_in.err   = rsp_in.valid & acc_oor;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= RSP_IDLE;
    end else begin
      pipe[0] <= rsp_in;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_out = pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_fetch_gnt = fetch_win;
  assign o_data_gnt  = data_win;
  assign o_rvalid    = rsp_out.valid;
  assign o_rsrc      = rsp_out.valid & (rsp_out.src == SRC_DATA);
  assign o_data_read = rsp_out.valid ? rsp_out.data : '0;
  assign o_err       = (rsp_out.valid & rsp_out.err)
                     | (write_gnt & (acc_oor | i_read_req));

endmodule

// File: tb/tb_zacore_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_zacore_mem_responder
// Directed and randomized checks of zacore_mem_responder against a behavioural
// model: an associative word memory, a queue of expected responses tagged with
// the cycle they are due, and a count of consecutive fetch denials.
// -----------------------------------------------------------------------------
module tb_zacore_mem_responder;
  import zacore_pkg::*;

  localparam int DEPTH = 4096;
  localparam int LAT   = 3;
  localparam int LIMIT = 4;

  logic  i_clk = 1'b0;
  logic  i_rst = 1'b0;
  logic  i_fetch_req = 1'b0;
  logic  i_read_req = 1'b0;
  logic  i_write_req = 1'b0;
  word_t i_fetch_addr = '0;
  word_t i_data_addr = '0;
  word_t i_data_write = '0;
  mask_t i_data_write_mask = '0;
  logic  o_fetch_gnt;
  logic  o_data_gnt;
  word_t o_data_read;
  logic  o_rvalid;
  logic  o_rsrc;
  logic  o_err;

  always #5 i_clk = ~i_clk;

  zacore_mem_responder #(
    .DEPTH_WORDS  (DEPTH),
    .LATENCY      (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_fetch_req       (i_fetch_req),
    .i_read_req        (i_read_req),
    .i_write_req       (i_write_req),
    .i_fetch_addr      (i_fetch_addr),
    .i_data_addr       (i_data_addr),
    .i_data_write      (i_data_write),
    .i_data_write_mask (i_data_write_mask),
    .o_fetch_gnt       (o_fetch_gnt),
    .o_data_gnt        (o_data_gnt),
    .o_data_read       (o_data_read),
    .o_rvalid          (o_rvalid),
    .o_rsrc            (o_rsrc),
    .o_err             (o_err)
  );

  typedef struct {
    int    due;
    logic  src;
    word_t data;
    logic  err;
  } exp_t;

  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    m_starve = 0;
  logic  last_fg  = 1'b0;
  word_t mem_m [int];
  exp_t  q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input word_t a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic oor(input word_t a);
    return a >= 32'(DEPTH * 4);
  endfunction

  function automatic word_t rd(input word_t a);
    return mem_m.exists(widx(a)) ? mem_m[widx(a)] : '0;
  endfunction

  task automatic wr(input word_t a, input word_t d, input mask_t m);
    word_t v = rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_m[widx(a)] = v;
  endtask

  // One bus cycle: drive, check at the falling edge, update the model at the
  // rising edge. Entered and left 1 time unit after a rising edge.
  task automatic step(input logic f, input logic r, input logic w,
                      input word_t fa, input word_t da, input word_t wd, input mask_t m);
    logic fg, dg, ev, wr_err;
    exp_t e = '{due: 0, src: 1'b0, data: '0, err: 1'b0};
    i_fetch_req = f;  i_read_req = r;  i_write_req = w;
    i_fetch_addr = fa; i_data_addr = da; i_data_write = wd; i_data_write_mask = m;
    @(negedge i_clk);
    fg = f && (!(r || w) || m_starve == LIMIT);
    dg = (r || w) && !fg;
    last_fg = o_fetch_gnt;
    check("fetch_gnt", 32'(o_fetch_gnt), 32'(fg));
    check("data_gnt", 32'(o_data_gnt), 32'(dg));
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      ev = 1'b1;
    end
    wr_err = dg && w && (oor(da) || r);
    check("rvalid", 32'(o_rvalid), 32'(ev));
    check("rdata", o_data_read, ev ? e.data : 32'h0);
    check("rsrc", 32'(o_rsrc), 32'(ev && e.src));
    check("err", 32'(o_err), 32'((ev && e.err) || wr_err));
    @(posedge i_clk);
    if (fg)
      q.push_back('{due: cyc + LAT, src: 1'b0, data: oor(fa) ? 32'h0 : rd(fa), err: oor(fa)});
    else if (dg && !w)
      q.push_back('{due: cyc + LAT, src: 1'b1, data: oor(da) ? 32'h0 : rd(da), err: oor(da)});
    else if (dg && w && !oor(da))
      wr(da, wd, m);
    m_starve = (f && !fg) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // Assert reset immediately with every request active; outputs must stay 0
  // and nothing may be written. Released between rising edges.
  task automatic reset_phase(input int n);
    i_rst = 1'b0;
    i_fetch_req = 1'b1; i_read_req = 1'b1; i_write_req = 1'b1;
    i_fetch_addr = 32'h10; i_data_addr = 32'h10;
    i_data_write = $urandom; i_data_write_mask = 4'hF;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      check("rst_fetch_gnt", 32'(o_fetch_gnt), 32'h0);
      check("rst_data_gnt", 32'(o_data_gnt), 32'h0);
      check("rst_rvalid", 32'(o_rvalid), 32'h0);
      check("rst_rdata", o_data_read, 32'h0);
      check("rst_rsrc", 32'(o_rsrc), 32'h0);
      check("rst_err", 32'(o_err), 32'h0);
      @(posedge i_clk);
      cyc++;
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    i_fetch_req = 1'b0; i_read_req = 1'b0; i_write_req = 1'b0;
    q.delete();
    m_starve = 0;
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  initial begin
    // Reset state
    reset_phase(3);

    // Full write then read back
    step(0, 0, 1, '0, 32'h10, 32'hDEADBEEF, 4'hF);
    step(0, 1, 0, '0, 32'h10, '0, '0);
    idle(LAT + 1);

    // Single-byte masked write, then a read the very next cycle
    step(0, 0, 1, '0, 32'h10, 32'h000000AA, 4'b0001);
    step(0, 1, 0, '0, 32'h10, '0, '0);
    // Mask 0 is a no-op
    step(0, 0, 1, '0, 32'h10, 32'h11111111, 4'b0000);
    step(0, 1, 0, '0, 32'h10, '0, '0);
    idle(LAT + 1);

    // Fetch starvation: fetch+read held; grant pattern D D D D F repeating
    step(0, 0, 1, '0, 32'h100, 32'h600DC0DE, 4'hF);
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 0, 32'h100, 32'h10, '0, '0);
      check("starve_pattern", 32'(last_fg), 32'((i % 5) == 4));
    end
    idle(LAT + 1);

    // Out-of-range read and write; the write must not alias onto word 0
    step(0, 0, 1, '0, 32'h0, 32'h0BADF00D, 4'hF);
    step(0, 1, 0, '0, 32'h4000, '0, '0);
    step(0, 0, 1, '0, 32'h4000, 32'h12345678, 4'hF);
    step(1, 0, 0, 32'h4000, '0, '0, '0);
    step(0, 1, 0, '0, 32'h0, '0, '0);
    idle(LAT + 1);

    // Read and write together: write commits, error flagged, no response
    step(0, 1, 1, '0, 32'h20, 32'hCAFEF00D, 4'hF);
    idle(LAT + 1);
    step(0, 1, 0, '0, 32'h20, '0, '0);
    idle(LAT + 1);

    // Reset with a read in flight: response discarded, memory kept
    step(0, 1, 0, '0, 32'h10, '0, '0);
    reset_phase(2);
    idle(LAT + 3);
    step(0, 1, 0, '0, 32'h10, '0, '0);
    idle(LAT + 1);

    // Randomized traffic over a pre-filled window plus out-of-range hits
    for (int i = 0; i < 64; i++) step(0, 0, 1, '0, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 500; i++) begin
      logic  f, r, w;
      word_t fa, da;
      f  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 1) != 0);
      w  = ($urandom_range(0, 3) == 0);
      fa = ($urandom_range(0, 9) == 0) ? (32'h4000 + 32'($urandom_range(0, 255)))
                                       : 32'($urandom_range(0, 255));
      da = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h8000_0000)
                                       : 32'($urandom_range(0, 255));
      step(f, r, w, fa, da, $urandom, 4'($urandom));
    end
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
